// File: rtl/m_lsu_pkg.sv
// Shared constants for the M-stage load/store unit: access types, CP0 exception
// codes, FSM states and address-map defaults.
package m_lsu_pkg;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LHU  = 4'd3;
    localparam logic [3:0] OP_LB   = 4'd4;
    localparam logic [3:0] OP_LBU  = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SB   = 4'd8;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    localparam logic [31:0] DM_LO_DEF  = 32'h0000_0000;
    localparam logic [31:0] DM_HI_DEF  = 32'h0000_2FFF;
    localparam logic [31:0] DEV_LO_DEF = 32'h0000_7F00;
    localparam logic [31:0] DEV_HI_DEF = 32'h0000_7F1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op >= OP_LW) && (op <= OP_LBU);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op >= OP_SW) && (op <= OP_SB);
    endfunction

    function automatic logic op_is_word(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic op_is_half(input logic [3:0] op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

endpackage

// File: rtl/m_lsu_align.sv
// Byte-lane steering for the LSU: byte enables and store-data replication on the
// way out, lane select and sign/zero extension of read data on the way back.
module m_lsu_align
    import m_lsu_pkg::*;
(
    input  logic [3:0]  st_op_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [3:0]  ld_op_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] shifted_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Byte enables follow the access size and offset for loads and stores alike
    always_comb begin
        be_o = 4'b0000;
        case (st_op_i)
            OP_LW, OP_SW:          be_o = 4'b1111;
            OP_LH, OP_LHU, OP_SH:  be_o = st_off_i[1] ? 4'b1100 : 4'b0011;
            OP_LB, OP_LBU, OP_SB:  be_o = 4'b0001 << st_off_i;
            default:               be_o = 4'b0000;
        endcase
    end

    // Store data replicated across lanes so the slave picks it up under any enable
    always_comb begin
        wdata_o = 32'h0000_0000;
        case (st_op_i)
            OP_SW:   wdata_o = st_data_i;
            OP_SH:   wdata_o = {2{st_data_i[15:0]}};
            OP_SB:   wdata_o = {4{st_data_i[7:0]}};
            default: wdata_o = 32'h0000_0000;
        endcase
    end

    assign shifted_s = rdata_i >> {ld_off_i, 3'b000};
    assign byte_s    = shifted_s[7:0];
    assign half_s    = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Load lane extraction; stores return zero toward the M/W register
    always_comb begin
        ld_data_o = 32'h0000_0000;
        case (ld_op_i)
            OP_LW:   ld_data_o = rdata_i;
            OP_LH:   ld_data_o = {{16{half_s[15]}}, half_s};
            OP_LHU:  ld_data_o = {16'h0000, half_s};
            OP_LB:   ld_data_o = {{24{byte_s[7]}}, byte_s};
            OP_LBU:  ld_data_o = {24'h00_0000, byte_s};
            default: ld_data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/m_lsu.sv
// M-stage load/store unit: address checks, request/ack bus FSM and pipeline stall.
// Optional BUS_TIMEOUT_EN aborts a stuck access with a DBE exception.
module m_lsu
    import m_lsu_pkg::*;
#(
    parameter logic [31:0] DM_LO  = DM_LO_DEF,
    parameter logic [31:0] DM_HI  = DM_HI_DEF,
    parameter logic [31:0] DEV_LO = DEV_LO_DEF,
    parameter logic [31:0] DEV_HI = DEV_HI_DEF
`ifdef BUS_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic [31:0] dm_out,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] dm_out_q, dm_out_d;
`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  cnt_q, cnt_d;
`endif

    logic        stall_s, exc_valid_s;
    logic [4:0]  exc_code_s;
    logic        op_ld_s, op_st_s, op_word_s, op_half_s, acc_s;
    logic        misalign_s, in_dm_s, in_dev_s, bad_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_rep_s, ld_data_s;

    assign op_ld_s   = op_is_load(mem_op);
    assign op_st_s   = op_is_store(mem_op);
    assign op_word_s = op_is_word(mem_op);
    assign op_half_s = op_is_half(mem_op);
    assign acc_s     = op_ld_s | op_st_s;

    // Offset-from-base compares stay correct when a range starts at address zero
    assign in_dm_s    = (addr - DM_LO) <= (DM_HI - DM_LO);
    assign in_dev_s   = (addr - DEV_LO) <= (DEV_HI - DEV_LO);
    assign misalign_s = (op_word_s && (addr[1:0] != 2'b00)) || (op_half_s && addr[0]);
    assign bad_s      = misalign_s
                      || (!in_dm_s && !in_dev_s)
                      || (in_dev_s && !op_word_s)
                      || (op_st_s && (addr == DEV_LO + 32'd8));

    m_lsu_align u_align (
        .st_op_i   (mem_op),
        .st_off_i  (addr[1:0]),
        .st_data_i (wdata),
        .be_o      (be_s),
        .wdata_o   (wdata_rep_s),
        .ld_op_i   (op_q),
        .ld_off_i  (off_q),
        .rdata_i   (bus_rdata),
        .ld_data_o (ld_data_s)
    );

    // Next-state, stall and exception decode
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        dm_out_d    = dm_out_q;
        stall_s     = 1'b0;
        exc_valid_s = 1'b0;
        exc_code_s  = 5'd0;
`ifdef BUS_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (acc_s && bad_s) begin
                    exc_valid_s = 1'b1;
                    exc_code_s  = op_st_s ? EXC_ADES : EXC_ADEL;
                end else begin
                    exc_valid_s = 1'b0;
                end
                if (acc_s && !bad_s && !req) begin
                    stall_s     = 1'b1;
                    state_d     = ST_REQ;
                    op_d        = mem_op;
                    off_d       = addr[1:0];
                    bus_req_d   = 1'b1;
                    bus_we_d    = op_st_s;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_be_d    = be_s;
                    bus_wdata_d = wdata_rep_s;
`ifdef BUS_TIMEOUT_EN
                    cnt_d       = 8'd0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (req) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                end else if (bus_ack) begin
                    stall_s   = 1'b1;
                    state_d   = ST_DONE;
                    bus_req_d = 1'b0;
                    dm_out_d  = ld_data_s;
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = ST_IDLE;
                    bus_req_d   = 1'b0;
                    exc_valid_s = 1'b1;
                    exc_code_s  = EXC_DBE;
                end
`endif
                else begin
                    stall_s = 1'b1;
`ifdef BUS_TIMEOUT_EN
                    cnt_d   = cnt_q + 8'd1;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and bus-side registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NONE;
            off_q       <= 2'b00;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0000_0000;
            dm_out_q    <= 32'h0000_0000;
`ifdef BUS_TIMEOUT_EN
            cnt_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            dm_out_q    <= dm_out_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign stall     = stall_s;
    assign exc_valid = exc_valid_s;
    assign exc_code  = exc_code_s;
    assign dm_out    = dm_out_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule
